// File: rtl/multdiv_stall_controller.sv
// multdiv_stall_controller
// Hazard controller that sits beside the execute-stage bypass network.
// It detects load-use hazards that bypassing cannot cover. It also runs the
// multi-cycle multdiv unit for mult/div instructions in execute. While
// multdiv is working, it holds the front of the pipeline and feeds nops into X/M.
module multdiv_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] decodeIR,
  input  logic [31:0] executeIR,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        stall_FD,
  output logic        stall_DX,
  output logic        nop_DX,
  output logic        nop_XM,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_latch,
  output logic        md_exc_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  logic [4:0] ex_op;
  logic [4:0] ex_rd;
  logic [4:0] ex_aluop;
  logic [4:0] dec_op;
  logic [4:0] dec_rd;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       ex_is_md;
  logic       ex_is_div;
  logic       start_seq;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       load_use;
  logic       unused_bits;

  assign ex_op    = executeIR[31:27];
  assign ex_rd    = executeIR[26:22];
  assign ex_aluop = executeIR[6:2];
  assign dec_op   = decodeIR[31:27];
  assign dec_rd   = decodeIR[26:22];
  assign dec_rs1  = decodeIR[21:17];
  assign dec_rs2  = decodeIR[16:12];

  assign unused_bits = ^{decodeIR[11:0], executeIR[21:7], executeIR[1:0]};

  assign ex_is_md  = (ex_op == OP_ALU) && ((ex_aluop == ALU_MUL) || (ex_aluop == ALU_DIV));
  assign ex_is_div = (ex_aluop == ALU_DIV);
  assign start_seq = (state == IDLE) && ex_is_md;
  assign busy      = (state != IDLE);

  // Select which registers the decode instruction reads; r0 in a slot means "none"
  always_comb begin
    src_a = 5'd0;
    src_b = 5'd0;
    case (dec_op)
      OP_ALU:                begin src_a = dec_rs1; src_b = dec_rs2; end
      OP_ADDI, OP_LW, OP_SW: begin src_a = dec_rs1; end
      OP_BNE, OP_BLT:        begin src_a = dec_rd;  src_b = dec_rs1; end
      OP_JR:                 begin src_a = dec_rd; end
      OP_BEX:                begin src_a = 5'd30; end
      default:               begin src_a = 5'd0;  src_b = 5'd0; end
    endcase
  end

  assign load_use = (ex_op == OP_LW) && (ex_rd != 5'd0) &&
                    ((ex_rd == src_a) || (ex_rd == src_b));

  // State, busy counter and registered multdiv start pulses (high only in START)
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
    end else begin
      state     <= next_state;
      ctrl_MULT <= start_seq && !ex_is_div;
      ctrl_DIV  <= start_seq && ex_is_div;
      if (state == START) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Next state plus the combinational stall, nop and latch controls
  always_comb begin
    next_state = state;
    stall_FD   = 1'b0;
    stall_DX   = 1'b0;
    nop_DX     = 1'b0;
    nop_XM     = 1'b0;
    md_latch   = 1'b0;
    md_exc_out = 1'b0;
    case (state)
      IDLE: begin
        if (ex_is_md) begin
          stall_FD   = 1'b1;
          stall_DX   = 1'b1;
          nop_XM     = 1'b1;
          next_state = START;
        end else if (load_use) begin
          stall_FD = 1'b1;
          nop_DX   = 1'b1;
        end
      end
      START: begin
        stall_FD   = 1'b1;
        stall_DX   = 1'b1;
        nop_XM     = 1'b1;
        next_state = BUSY;
      end
      BUSY: begin
        if (md_resultRDY) begin
          md_latch   = 1'b1;
          md_exc_out = md_exception;
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          md_latch   = 1'b1;
          md_exc_out = 1'b1;
          next_state = IDLE;
        end else begin
          stall_FD = 1'b1;
          stall_DX = 1'b1;
          nop_XM   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// Testbench for multdiv_stall_controller.
// The bench runs table-driven load-use vectors, hand-written multdiv
// sequences and a randomized run. Every cycle is compared against a
// cycle-age reference model.
module tb_multdiv_stall_controller;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] decodeIR;
  logic [31:0] executeIR;
  logic        md_resultRDY;
  logic        md_exception;
  logic        stall_FD, stall_DX, nop_DX, nop_XM;
  logic        ctrl_MULT, ctrl_DIV, md_latch, md_exc_out, busy;

  int tests = 0;
  int fails = 0;

  // Model: age < 0 means idle, 1 means the start cycle, n >= 2 means busy cycle n-1
  int          age = -1;
  bit          kindDiv = 1'b0;
  logic [8:0]  act;
  logic [8:0]  lastExp = '0;
  int          globalCycle = 0;

  always #5 clock = ~clock;

  multdiv_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clock(clock), .reset(reset),
    .decodeIR(decodeIR), .executeIR(executeIR),
    .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .stall_FD(stall_FD), .stall_DX(stall_DX), .nop_DX(nop_DX), .nop_XM(nop_XM),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_latch(md_latch), .md_exc_out(md_exc_out), .busy(busy)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] aluop);
    return {op, rd, rs1, rs2, 5'd0, aluop, 2'b00};
  endfunction

  function automatic bit isMD(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  function automatic bit readsReg(input logic [31:0] ir, input logic [4:0] r);
    logic [4:0] rd, rs1, rs2;
    rd = ir[26:22]; rs1 = ir[21:17]; rs2 = ir[16:12];
    case (ir[31:27])
      5'd0:        return (r == rs1) || (r == rs2);
      5'd5, 5'd8:  return r == rs1;
      5'd7:        return r == rs1;
      5'd2, 5'd6:  return (r == rd) || (r == rs1);
      5'd4:        return r == rd;
      5'd22:       return r == 5'd30;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic bit loadUse(input logic [31:0] ex, input logic [31:0] dec);
    return (ex[31:27] == 5'd8) && (ex[26:22] != 5'd0) && readsReg(dec, ex[26:22]);
  endfunction

  // Expected bits: {FD, DX, nopDX, nopXM, MULT, DIV, latch, exc, busy}
  task automatic modelEval(output logic [8:0] exp, output int na, output bit nd);
    exp = '0;
    na  = age;
    nd  = kindDiv;
    if (age < 0) begin
      if (isMD(executeIR)) begin
        exp[8] = 1'b1; exp[7] = 1'b1; exp[5] = 1'b1;
        na = 1;
        nd = (executeIR[6:2] == 5'd7);
      end else if (loadUse(executeIR, decodeIR)) begin
        exp[8] = 1'b1; exp[6] = 1'b1;
      end
    end else if (age == 1) begin
      exp[8] = 1'b1; exp[7] = 1'b1; exp[5] = 1'b1; exp[0] = 1'b1;
      if (kindDiv) exp[3] = 1'b1;
      else exp[4] = 1'b1;
      na = 2;
    end else begin
      exp[0] = 1'b1;
      if (md_resultRDY) begin
        exp[2] = 1'b1; exp[1] = md_exception; na = -1;
      end else if (age - 1 == TIMEOUT) begin
        exp[2] = 1'b1; exp[1] = 1'b1; na = -1;
      end else begin
        exp[8] = 1'b1; exp[7] = 1'b1; exp[5] = 1'b1;
        na = age + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ex, input logic [31:0] dec,
                               input logic rdy, input logic exc, input logic rst);
    executeIR    = ex;
    decodeIR     = dec;
    md_resultRDY = rdy;
    md_exception = exc;
    reset        = rst;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got %b want %b (FD DX nopDX nopXM MULT DIV latch exc busy)",
               name, globalCycle, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Starts just after a falling edge with inputs applied; ends at the next falling edge
  task automatic runCycle(input string name);
    logic [8:0] exp;
    int         na;
    bit         nd;
    modelEval(exp, na, nd);
    #1;
    act = {stall_FD, stall_DX, nop_DX, nop_XM, ctrl_MULT, ctrl_DIV, md_latch, md_exc_out, busy};
    if (!reset) checkOutput(name, exp);
    lastExp = exp;
    @(posedge clock);
    if (reset) age = -1;
    else begin
      age = na;
      kindDiv = nd;
    end
    globalCycle++;
    @(negedge clock);
  endtask

  function automatic logic [4:0] randReg();
    return ($urandom % 8 == 0) ? 5'd30 : 5'($urandom % 4);
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0] ops [12];
    logic [4:0] alus [4];
    ops  = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd5, 5'd7, 5'd2, 5'd6, 5'd4, 5'd22, 5'd3, 5'd1};
    alus = '{5'd6, 5'd7, 5'd0, 5'd1};
    return mk(ops[$urandom % 12], randReg(), randReg(), randReg(), alus[$urandom % 4]);
  endfunction

  typedef struct {
    logic [31:0] ex;
    logic [31:0] dec;
    logic [3:0]  exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [16];
    logic [31:0] NOP, SAFE, MULT, MULT2, DIV, LW5;
    int          stallCnt, mulPulses, divPulses, latchAt, excAt, latchCnt;
    int          firstPulse, secondPulse;

    NOP   = 32'd0;
    SAFE  = mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
    MULT  = mk(5'd0, 5'd7, 5'd1, 5'd2, 5'd6);
    MULT2 = mk(5'd0, 5'd4, 5'd1, 5'd2, 5'd6);
    DIV   = mk(5'd0, 5'd7, 5'd1, 5'd2, 5'd7);
    LW5   = mk(5'd8, 5'd5, 5'd3, 5'd0, 5'd0);

    // exp = {stall_FD, stall_DX, nop_DX, nop_XM}
    vecs[0]  = '{LW5, mk(5'd0, 5'd1, 5'd5, 5'd2, 5'd0), 4'b1010};
    vecs[1]  = '{mk(5'd8, 5'd0, 5'd3, 5'd0, 5'd0), mk(5'd0, 5'd1, 5'd0, 5'd2, 5'd0), 4'b0000};
    vecs[2]  = '{LW5, mk(5'd7, 5'd5, 5'd3, 5'd0, 5'd0), 4'b0000};
    vecs[3]  = '{LW5, mk(5'd7, 5'd1, 5'd5, 5'd0, 5'd0), 4'b1010};
    vecs[4]  = '{LW5, mk(5'd5, 5'd5, 5'd2, 5'd0, 5'd0), 4'b0000};
    vecs[5]  = '{LW5, mk(5'd5, 5'd1, 5'd5, 5'd0, 5'd0), 4'b1010};
    vecs[6]  = '{LW5, mk(5'd2, 5'd5, 5'd1, 5'd2, 5'd0), 4'b1010};
    vecs[7]  = '{LW5, mk(5'd6, 5'd1, 5'd5, 5'd2, 5'd0), 4'b1010};
    vecs[8]  = '{LW5, mk(5'd6, 5'd1, 5'd2, 5'd5, 5'd0), 4'b0000};
    vecs[9]  = '{LW5, mk(5'd4, 5'd5, 5'd1, 5'd0, 5'd0), 4'b1010};
    vecs[10] = '{LW5, mk(5'd4, 5'd1, 5'd5, 5'd0, 5'd0), 4'b0000};
    vecs[11] = '{mk(5'd8, 5'd30, 5'd1, 5'd0, 5'd0), mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd0), 4'b1010};
    vecs[12] = '{mk(5'd8, 5'd29, 5'd1, 5'd0, 5'd0), mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd0), 4'b0000};
    vecs[13] = '{mk(5'd0, 5'd5, 5'd1, 5'd2, 5'd0), mk(5'd0, 5'd1, 5'd5, 5'd2, 5'd0), 4'b0000};
    vecs[14] = '{LW5, mk(5'd0, 5'd1, 5'd2, 5'd5, 5'd0), 4'b1010};
    vecs[15] = '{LW5, mk(5'd3, 5'd1, 5'd5, 5'd0, 5'd0), 4'b0000};

    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    runCycle("reset");
    runCycle("reset");
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b0);
    runCycle("after_reset");
    checkValue("reset_outputs", int'(act), 0);

    // Load-use decode-source table
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ex, vecs[i].dec, 1'b0, 1'b0, 1'b0);
      runCycle($sformatf("loaduse_vec%0d", i));
      checkValue($sformatf("loaduse_tbl%0d", i), int'(act[8:5]), int'(vecs[i].exp));
    end

    // mult with RDY 17 cycles after START
    applyStimulus(MULT, SAFE, 1'b0, 1'b0, 1'b0);
    stallCnt = 0; mulPulses = 0; latchAt = -1;
    for (int i = 0; i <= 18; i++) begin
      md_resultRDY = (i == 18);
      runCycle("mult17");
      if (act[8]) stallCnt++;
      if (act[4]) mulPulses++;
      if (act[2] && latchAt < 0 && act[8] == 1'b0) latchAt = i;
    end
    checkValue("mult17_stall_cycles", stallCnt, 18);
    checkValue("mult17_pulses", mulPulses, 1);
    checkValue("mult17_latch_cycle", latchAt, 18);
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b0);
    runCycle("mult17_idle");
    checkValue("mult17_busy_after", int'(act[0]), 0);

    // div finishing with an exception
    applyStimulus(DIV, SAFE, 1'b0, 1'b0, 1'b0);
    divPulses = 0; mulPulses = 0; excAt = -1;
    for (int i = 0; i <= 5; i++) begin
      md_resultRDY = (i == 5);
      md_exception = (i == 5);
      runCycle("div_exc");
      if (act[3]) divPulses++;
      if (act[4]) mulPulses++;
      if (act[2] && act[1]) excAt = i;
    end
    checkValue("div_pulses", divPulses, 1);
    checkValue("div_no_mult", mulPulses, 0);
    checkValue("div_exc_cycle", excAt, 5);
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b0);
    runCycle("div_idle");
    checkValue("div_busy_after", int'(act[0]), 0);

    // Two adjacent mults
    mulPulses = 0; latchCnt = 0; firstPulse = -1; secondPulse = -1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus((k == 0) ? MULT : MULT2, SAFE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= 4; i++) begin
        md_resultRDY = (i == 4);
        runCycle("b2b");
        if (act[4]) begin
          mulPulses++;
          if (firstPulse < 0) firstPulse = globalCycle;
          else secondPulse = globalCycle;
        end
        if (act[2]) latchCnt++;
      end
    end
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b0);
    runCycle("b2b_idle");
    checkValue("b2b_pulses", mulPulses, 2);
    checkValue("b2b_latches", latchCnt, 2);
    checkValue("b2b_pulse_gap", secondPulse - firstPulse, 5);

    // RDY never arrives: forced abort on BUSY cycle 64
    applyStimulus(MULT, SAFE, 1'b0, 1'b0, 1'b0);
    stallCnt = 0; latchAt = -1; excAt = 0;
    for (int i = 0; i <= 65; i++) begin
      runCycle("timeout");
      if (act[8]) stallCnt++;
      if (act[2] && latchAt < 0) begin
        latchAt = i;
        excAt = int'(act[1]);
      end
    end
    checkValue("timeout_cycle", latchAt, 65);
    checkValue("timeout_exc", excAt, 1);
    checkValue("timeout_stall_cycles", stallCnt, 65);
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b0);
    runCycle("timeout_idle");
    checkValue("timeout_busy_after", int'(act[0]), 0);

    // Reset during BUSY, then a stray RDY
    applyStimulus(MULT, SAFE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) runCycle("rst_busy_pre");
    checkValue("rst_busy_was_busy", int'(act[0]), 1);
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b1);
    runCycle("rst_busy");
    applyStimulus(NOP, SAFE, 1'b0, 1'b0, 1'b0);
    runCycle("rst_after");
    checkValue("rst_after_outputs", int'(act), 0);
    applyStimulus(NOP, SAFE, 1'b1, 1'b1, 1'b0);
    runCycle("rst_stray_rdy");
    checkValue("rst_stray_rdy_outputs", int'(act), 0);
    md_resultRDY = 1'b0;
    md_exception = 1'b0;

    // Randomized run; held instructions follow the expected latch enables
    lastExp = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!lastExp[7]) executeIR = randInstr();
      if (!lastExp[8]) decodeIR = randInstr();
      md_resultRDY = ($urandom % 6 == 0);
      md_exception = 1'($urandom % 2);
      reset        = ($urandom % 300 == 0);
      runCycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
